// File: rtl/icache.sv
// icache - direct-mapped, read-only instruction cache.
//
// Returns the instruction word for the fetch address in the same cycle on a
// hit. On a miss it stalls the PC and fills the whole line from a backing
// memory, starting at word 0. The backing read port allows one request in
// flight at a time.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req_vld/i_req_addr fetch request from IF (addr[1:0] ignored)
//   o_res_rdata          instruction word (0 unless o_res_vld)
//   o_res_vld            hit this cycle
//   o_busy               stall to PC (request present and not a hit)
//   i_inv                invalidate all lines (fence.i)
//   o_mem_ren/o_mem_addr backing read request and word address
//   i_mem_ready          backing memory accepts the request
//   i_mem_valid/i_mem_rdata backing read data return
//
// Optional build macro ICACHE_STATS_EN adds o_hit_cnt / o_miss_cnt, two
// free-running 32-bit wrapping counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | serve hits; on a miss latch the line base and start the fill
// REQ   | present read for word cnt, hold until i_mem_ready
// WAIT  | wait for i_mem_valid, store the word, next word or install

module icache #(
    parameter int          NUM_LINES      = 16,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] RESET_ADDR     = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_vld,
    input  logic [31:0] i_req_addr,
    output logic [31:0] o_res_rdata,
    output logic        o_res_vld,
    output logic        o_busy,
    input  logic        i_inv,
    output logic        o_mem_ren,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt
`endif
);

    localparam int WW  = $clog2(WORDS_PER_LINE);
    localparam int IW  = $clog2(NUM_LINES);
    localparam int OFF = WW + 2;
    localparam int TW  = 32 - OFF - IW;

    localparam logic [WW-1:0] CNT_LAST = WW'(WORDS_PER_LINE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]           state_q;
    logic [TW-1:0]        fill_tag_q;
    logic [IW-1:0]        fill_idx_q;
    logic [WW-1:0]        cnt_q;
    logic                 kill_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [WW-1:0] req_word;
    logic          hit;
    logic          miss_start;
    logic          beat;
    logic          last_beat;
    logic          unused_addr_lsb;

    assign req_word        = i_req_addr[OFF-1:2];
    assign req_idx         = i_req_addr[OFF+IW-1:OFF];
    assign req_tag         = i_req_addr[31:OFF+IW];
    assign unused_addr_lsb = ^i_req_addr[1:0];

    // Hits are only reported from IDLE so a fill never races a lookup.
    assign hit        = i_req_vld & valid_q[req_idx] & (tag_q[req_idx] == req_tag)
                        & (state_q == ST_IDLE);
    assign miss_start = (state_q == ST_IDLE) & i_req_vld & ~hit;
    assign beat       = (state_q == ST_WAIT) & i_mem_valid;
    assign last_beat  = beat & (cnt_q == CNT_LAST);

    assign o_res_vld   = hit;
    assign o_res_rdata = hit ? data_q[req_idx][req_word] : 32'h0;
    assign o_busy      = i_req_vld & ~hit;
    assign o_mem_ren   = (state_q == ST_REQ);
    // The line base has word 0, so base + 4*cnt is a plain concatenation.
    assign o_mem_addr  = (state_q == ST_IDLE) ? RESET_ADDR
                                               : {fill_tag_q, fill_idx_q, cnt_q, 2'b00};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
            valid_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_start) begin
                        fill_tag_q <= req_tag;
                        fill_idx_q <= req_idx;
                        cnt_q      <= '0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_mem_ready) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mem_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= ST_REQ;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // An invalidate during a fill must keep that line from being
            // validated when it lands; the flag lives only for this fill.
            if (last_beat) kill_q <= 1'b0;
            else if (i_inv && (state_q != ST_IDLE)) kill_q <= 1'b1;

            // Invalidate wins over a coincident install.
            if (i_inv) valid_q <= '0;
            else if (last_beat && !kill_q) valid_q[fill_idx_q] <= 1'b1;
        end
    end

    // Storage arrays carry no reset; the valid bits guard every read.
    always_ff @(posedge i_clk) begin
        if (!i_rst && beat) data_q[fill_idx_q][cnt_q] <= i_mem_rdata;
        if (!i_rst && last_beat) tag_q[fill_idx_q] <= fill_tag_q;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hit_cnt  <= 32'h0;
            o_miss_cnt <= 32'h0;
        end else begin
            if (hit)        o_hit_cnt  <= o_hit_cnt + 32'd1;
            if (miss_start) o_miss_cnt <= o_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache - self-checking bench for icache (default parameters).
// A behavioural model keeps per-line valid/tag from address arithmetic; the
// backing memory returns data equal to the word address with random
// ready/valid delays and records every accepted request.

module tb_icache;

    logic        clk;
    logic        i_rst;
    logic        i_req_vld;
    logic [31:0] i_req_addr;
    logic [31:0] o_res_rdata;
    logic        o_res_vld;
    logic        o_busy;
    logic        i_inv;
    logic        o_mem_ren;
    logic [31:0] o_mem_addr;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] o_hit_cnt;
    logic [31:0] o_miss_cnt;
`endif

    icache dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_vld   (i_req_vld),
        .i_req_addr  (i_req_addr),
        .o_res_rdata (o_res_rdata),
        .o_res_vld   (o_res_vld),
        .o_busy      (o_busy),
        .i_inv       (i_inv),
        .o_mem_ren   (o_mem_ren),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ready (i_mem_ready),
        .i_mem_valid (i_mem_valid),
        .i_mem_rdata (i_mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .o_hit_cnt   (o_hit_cnt),
        .o_miss_cnt  (o_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model: line state as seen by the fetch unit
    bit          m_valid [16];
    logic [31:0] m_tag   [16];

    // backing memory controls and observations
    int          ready_min = 0;
    int          ready_max = 0;
    int          lat_max   = 0;
    int          penalty_acc = 0;
    bit          stray_pulse = 0;
    logic [31:0] acc_q [$];

    initial begin
        int stall, lat_cnt, lat_next;
        bit lat_pend, was_req;
        logic [31:0] lat_addr;
        i_mem_ready = 0; i_mem_valid = 0; i_mem_rdata = 0;
        stall = 0; lat_cnt = 0; lat_next = 0; lat_pend = 0; was_req = 0; lat_addr = 0;
        forever begin
            @(negedge clk);
            i_mem_valid = 0; i_mem_ready = 0; i_mem_rdata = 32'h0;
            if (i_rst) begin
                lat_pend = 0; was_req = 0;
            end else begin
                if (lat_pend) begin
                    if (lat_cnt == 0) begin
                        i_mem_valid = 1; i_mem_rdata = lat_addr; lat_pend = 0;
                    end else lat_cnt--;
                end else if (stray_pulse) begin
                    i_mem_valid = 1; i_mem_rdata = 32'hDEADBEEF; stray_pulse = 0;
                end
                if (o_mem_ren === 1'b1) begin
                    if (!was_req) begin
                        stall    = $urandom_range(ready_max, ready_min);
                        lat_next = $urandom_range(lat_max, 0);
                        // REQ lasts stall+1 cycles, WAIT lasts lat+1 cycles
                        penalty_acc += stall + 2 + lat_next;
                        was_req = 1;
                    end
                    if (stall > 0) stall--;
                    else begin
                        i_mem_ready = 1;
                        acc_q.push_back(o_mem_addr);
                        lat_pend = 1; lat_cnt = lat_next; lat_addr = o_mem_addr;
                        was_req = 0;
                    end
                end
            end
        end
    end

    task automatic model_clear();
        foreach (m_valid[k]) m_valid[k] = 0;
    endtask

    // One fetch held until the hit. inv_word >= 0 pulses i_inv in the first
    // WAIT cycle of that word, which forces a second fill of the same line.
    task automatic fetch(input logic [31:0] a, input int inv_word, input string nm);
        int idx, cyc, fills, bad_busy, unstable;
        logic [31:0] tg, base, want;
        bit exp_hit, inv_done, prev_ren;
        logic [31:0] prev_addr;
        idx  = int'((a / 16) % 16);
        tg   = a / 256;
        base = a - (a % 16);
        want = a - (a % 4);
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        i_req_vld = 1; i_req_addr = a; i_inv = 0;
        acc_q.delete(); penalty_acc = 0;
        #1;
        n_chk++;
        if (o_res_vld !== exp_hit) begin
            n_fail++;
            $display("FAIL %s hit a=%h: got %b want %b", nm, a, o_res_vld, exp_hit);
        end
        if (exp_hit) begin
            n_chk++;
            if (o_res_rdata !== want) begin
                n_fail++;
                $display("FAIL %s rdata a=%h: got %h want %h", nm, a, o_res_rdata, want);
            end
            n_chk++;
            if (o_mem_ren !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ren on hit: got %b want 0", nm, o_mem_ren);
            end
            return;
        end
        n_chk++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy detect: got %b want 1", nm, o_busy);
        end
        fills = (inv_word >= 0) ? 2 : 1;
        cyc = 0; bad_busy = 0; unstable = 0; inv_done = 0; prev_ren = 0; prev_addr = 0;
        while (o_res_vld !== 1'b1 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            i_inv = 0;
            if (inv_word >= 0 && !inv_done && acc_q.size() == inv_word + 1
                && o_mem_ren === 1'b0) begin
                i_inv = 1; inv_done = 1;
            end
            #1;
            if (o_res_vld !== 1'b1 && o_busy !== 1'b1) bad_busy++;
            if (prev_ren && o_mem_ren === 1'b1 && o_mem_addr !== prev_addr) unstable++;
            prev_ren  = (o_mem_ren === 1'b1);
            prev_addr = o_mem_addr;
        end
        n_chk++;
        if (o_res_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout a=%h: no hit after %0d cycles", nm, a, cyc);
            return;
        end
        n_chk++;
        if (o_res_rdata !== want) begin
            n_fail++;
            $display("FAIL %s fill rdata a=%h: got %h want %h", nm, a, o_res_rdata, want);
        end
        n_chk++;
        if (cyc !== fills + penalty_acc) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", nm, cyc, fills + penalty_acc);
        end
        n_chk++;
        if (acc_q.size() !== 4 * fills) begin
            n_fail++;
            $display("FAIL %s req count: got %0d want %0d", nm, acc_q.size(), 4 * fills);
        end else begin
            for (int k = 0; k < acc_q.size(); k++) begin
                n_chk++;
                if (acc_q[k] !== base + 4 * (k % 4)) begin
                    n_fail++;
                    $display("FAIL %s req addr %0d: got %h want %h", nm, k, acc_q[k],
                             base + 4 * (k % 4));
                end
            end
        end
        n_chk++;
        if (bad_busy !== 0) begin
            n_fail++;
            $display("FAIL %s busy during fill: got %0d low cycles want 0", nm, bad_busy);
        end
        n_chk++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL %s req hold: got %0d changes want 0", nm, unstable);
        end
        if (inv_word >= 0) model_clear();
        m_valid[idx] = 1;
        m_tag[idx]   = tg;
    endtask

    task automatic check_idle(input string nm);
        n_chk++;
        if (o_mem_ren !== 1'b0 || o_mem_addr !== 32'h0 || o_busy !== 1'b0
            || o_res_vld !== 1'b0 || o_res_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL %s idle outputs: got ren=%b addr=%h busy=%b vld=%b rdata=%h want 0 0 0 0 0",
                     nm, o_mem_ren, o_mem_addr, o_busy, o_res_vld, o_res_rdata);
        end
    endtask

    task automatic test_reset();
        i_rst = 1; i_req_vld = 0; i_req_addr = 32'h0; i_inv = 0;
        repeat (3) @(negedge clk);
        i_rst = 0;
        #1;
        check_idle("reset");
        model_clear();
    endtask

    task automatic test_cold_miss();
        ready_min = 0; ready_max = 0; lat_max = 0;
        fetch(32'h0000_0104, -1, "cold_miss");
    endtask

    task automatic test_same_line_hits();
        fetch(32'h0000_0100, -1, "hit0");
        fetch(32'h0000_0108, -1, "hit2");
        fetch(32'h0000_010C, -1, "hit3");
        @(negedge clk);
        i_req_vld = 0;
        #1;
`ifdef ICACHE_STATS_EN
        n_chk++;
        if (o_miss_cnt !== 32'd1 || o_hit_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL stats: got miss=%0d hit=%0d want 1 4", o_miss_cnt, o_hit_cnt);
        end
`endif
    endtask

    task automatic test_conflict();
        fetch(32'h0000_0204, -1, "conflict_a");
        fetch(32'h0000_0104, -1, "conflict_b");
    endtask

    task automatic test_backpressure();
        ready_min = 3; ready_max = 3; lat_max = 1;
        fetch(32'h0000_03A8, -1, "backpressure");
        ready_min = 0; ready_max = 0; lat_max = 0;
    endtask

    task automatic test_invalidate();
        // (a) pulse in IDLE, then refetch
        @(negedge clk);
        i_req_vld = 0; i_inv = 1;
        model_clear();
        fetch(32'h0000_0100, -1, "inv_idle");
        // hit coincident with invalidate still reported
        @(negedge clk);
        i_req_vld = 1; i_req_addr = 32'h0000_0108; i_inv = 1;
        #1;
        n_chk++;
        if (o_res_vld !== 1'b1 || o_res_rdata !== 32'h0000_0108) begin
            n_fail++;
            $display("FAIL inv_same_cycle_hit: got vld=%b rdata=%h want 1 00000108",
                     o_res_vld, o_res_rdata);
        end
        model_clear();
        fetch(32'h0000_0108, -1, "inv_refetch");
        // (b) during WAIT of word 2, (c) on the last-word install
        lat_max = 1;
        fetch(32'h0000_0504, 2, "inv_wait2");
        lat_max = 0;
        fetch(32'h0000_0604, 3, "inv_install");
        fetch(32'h0000_0608, -1, "inv_after");
    endtask

    task automatic test_random();
        logic [31:0] a;
        ready_min = 0; ready_max = 3; lat_max = 2;
        for (int i = 0; i < 80; i++) begin
            a = 32'h0100_0000 * $urandom_range(0, 1) + 256 * $urandom_range(0, 2)
              + 16 * $urandom_range(0, 15) + ($urandom & 15);
            fetch(a, -1, "random");
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                i_req_vld = 0;
                i_inv = ($urandom_range(0, 2) == 0);
                #1;
                n_chk++;
                if (o_busy !== 1'b0 || o_res_vld !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random gap: got busy=%b vld=%b want 0 0", o_busy, o_res_vld);
                end
                if (i_inv) model_clear();
            end
        end
        ready_min = 0; ready_max = 0; lat_max = 0;
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        ready_min = 2; ready_max = 2; lat_max = 0;
        @(negedge clk);
        i_req_vld = 1; i_req_addr = 32'h0000_07C0; i_inv = 0;
        cyc = 0;
        #1;
        while (o_mem_ren !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        n_chk++;
        if (o_mem_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid reach REQ: got ren=%b want 1", o_mem_ren);
        end
        i_rst = 1;
        @(negedge clk);
        i_req_vld = 0;
        @(negedge clk);
        i_rst = 0;
        stray_pulse = 1;
        model_clear();
        repeat (4) begin
            @(negedge clk);
            #1;
            check_idle("rst_mid");
        end
        ready_min = 0; ready_max = 1; lat_max = 1;
        fetch(32'h0000_0608, -1, "post_rst_a");
        fetch(32'h0000_07C0, -1, "post_rst_b");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_same_line_hits();
        test_conflict();
        test_backpressure();
        test_invalidate();
        test_random();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
Direct-mapped, read-only instruction cache. It is the responder to the program counter's instruction-fetch address (imem_raddr): it returns the instruction word and stalls the PC on a miss. Misses are filled from a backing memory through a single-outstanding req/ready/valid read port. It sits between the PC/IF stage and the instruction memory or bus.

Parameters:
NUM_LINES, 16, number of cache lines; power of 2, at least 2.
WORDS_PER_LINE, 4, 32-bit words per line; power of 2, at least 2.
RESET_ADDR, 32'h00000000, value of o_mem_addr while idle and after reset.

Ports:
i_clk  input  1  global clock
i_rst  input  1  synchronous active-high reset
i_req_vld  input  1  fetch request valid (IF stage active)
i_req_addr  input  32  fetch address; bits [1:0] ignored
o_res_rdata  output  32  instruction word; valid when o_res_vld=1
o_res_vld  output  1  hit this cycle: i_req_vld & line valid & tag match & state IDLE
o_busy  output  1  stall to PC: i_req_vld & ~o_res_vld; PC drives this into its halt input
i_inv  input  1  invalidate all lines (fence.i)
o_mem_ren  output  1  backing read request
o_mem_addr  output  32  backing word address, word aligned
i_mem_ready  input  1  backing memory accepts request this cycle
i_mem_valid  input  1  backing read data valid
i_mem_rdata  input  32  backing read data

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE)+2.
  - word = addr[OFF-1:2].
  - index = addr[OFF+log2(NUM_LINES)-1:OFF].
  - tag = the remaining upper bits.
  - Defaults: word=[3:2], index=[7:4], tag=[31:8].
- Storage: data array, tag array, and a valid bit per line, all in flops. Hit read is combinational from i_req_addr (0-cycle latency, as a single-cycle imem).
- Reset:
  - All valid bits cleared; state=IDLE.
  - o_mem_ren=0, o_mem_addr=RESET_ADDR, o_res_vld=0, o_busy=0 (with i_req_vld=0).
  - o_res_rdata=0 when not valid.
- State IDLE:
  - On i_req_vld & miss: latch miss line base (tag,index,word=0) into fill_addr, clear word counter, go to REQ.
  - o_busy=1 in the detect cycle.
- State REQ:
  - o_mem_ren=1, o_mem_addr=fill_addr + 4*cnt.
  - Hold both stable until i_mem_ready=1, then go to WAIT.
- State WAIT:
  - o_mem_ren=0.
  - On i_mem_valid: write i_mem_rdata to data[index][cnt].
  - If cnt==WORDS_PER_LINE-1: write the tag, set valid (unless killed), go to IDLE. Otherwise cnt+1, go to REQ.
- Miss penalty: WORDS_PER_LINE*(ready wait + valid wait + 1 REQ cycle) cycles.
  - The first request is issued in the cycle after detect.
  - The hit is seen in the cycle after the install.
- Fill granularity:
  - The whole line is always filled starting from word 0; there is no critical-word-first.
  - Word counter width is log2(WORDS_PER_LINE) and it wraps only at line end.
- i_req_addr changing or i_req_vld dropping during a fill:
  - The fill still completes for the latched line.
  - o_busy follows the current request, evaluated against IDLE only. It is 1 whenever state != IDLE and i_req_vld=1.
- i_mem_valid in IDLE or REQ is ignored.
- i_mem_ready outside REQ is ignored.
- i_inv:
  - In IDLE: clears all valid bits at the clock edge. A hit in that same cycle is still reported.
  - During REQ/WAIT: clears all valid bits and sets a kill flag. The fill completes but the line is not validated; the flag clears on return to IDLE.
  - If i_inv coincides with the last-word install: invalidate wins (line not valid).
- Reset mid-fill: immediate return to IDLE with all lines invalid. Stale i_mem_valid pulses afterward are ignored.
- Replacement: the line is overwritten unconditionally (direct mapped). The tag is written only at install.

Optional Feature:
Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs o_hit_cnt[31:0] and o_miss_cnt[31:0], both reset to 0.
  - o_hit_cnt increments in every cycle o_res_vld=1.
  - o_miss_cnt increments on every IDLE->REQ transition.
  - Both wrap at 2^32 (32'hFFFFFFFF -> 0).
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, i_req_vld=1, addr=0x00000104; memory has 0-cycle ready and 1-cycle valid latency, returning data = addr.
   - Response: o_busy=1; o_mem_addr sequence is 0x100, 0x104, 0x108, 0x10C; then o_res_vld=1 with rdata=0x104.
2. Same-line hits:
   - Stimulus: after test 1, addr=0x100, 0x108, 0x10C on consecutive cycles.
   - Response: o_res_vld=1 each cycle; rdata=0x100, 0x108, 0x10C; no o_mem_ren.
3. Conflict eviction:
   - Stimulus: fetch 0x204, then 0x104 (same index 0, tags differ).
   - Response: each fetch misses and refills. Second fill addresses are 0x100..0x10C.
4. Backpressure:
   - Stimulus: i_mem_ready low for 3 cycles during REQ.
   - Response: o_mem_ren and o_mem_addr held stable through the stall; exactly 4 accepted requests per line.
5. Invalidate:
   - Stimulus (a): i_inv pulse in IDLE, then refetch 0x100.
   - Response (a): miss.
   - Stimulus (b): i_inv during WAIT of word 2.
   - Response (b): fill finishes, then the next fetch of the same line misses again.
6. Reset mid-fill and stats:
   - Stimulus: i_rst in REQ, then a stray i_mem_valid.
   - Response: state IDLE, o_mem_ren=0, all lines miss.
   - With ICACHE_STATS_EN, after tests 1-2: o_miss_cnt=1, o_hit_cnt=4.
